// File: rtl/code_lock_pkg.sv
// Shared constants and state encoding for the 4-bit code-lock interface.
package code_lock_pkg;

  localparam int CODE_W    = 4;
  localparam int ATTEMPT_W = 5;

  localparam logic [CODE_W-1:0] CODE_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESENT,
    S_TRY,
    S_WAIT_READY,
    S_DONE,
    S_FAIL
  } probe_state_t;

endpackage

// File: rtl/code_lock_prober.sv
// Sequential initiator for the code-lock responder: sweeps candidate codes
// 0..15, holds each for SETTLE cycles, strobes try_out for one cycle and
// samples lock_match. Waits out responder lockout, bounded by WAIT_MAX.
module code_lock_prober
  import code_lock_pkg::*;
#(
  parameter int SETTLE   = 1,
  parameter int WAIT_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 lock_ready,
  input  logic                 lock_match,
  output logic [CODE_W-1:0]    code_out,
  output logic                 try_out,
  output logic                 busy,
  output logic                 found,
  output logic                 fail,
  output logic                 timeout,
  output logic [CODE_W-1:0]    result,
  output logic [ATTEMPT_W-1:0] attempts
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);
  localparam logic [7:0]       WAIT_LAST   = 8'(WAIT_MAX - 1);

  probe_state_t         state, state_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic [CODE_W-1:0]    result_q, result_d;
  logic [ATTEMPT_W-1:0] att_q, att_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [7:0]           wait_q, wait_d;
  logic                 tmo_q, tmo_d;

  // State and datapath registers; async reset returns every output to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      code_q   <= '0;
      result_q <= '0;
      att_q    <= '0;
      settle_q <= '0;
      wait_q   <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state    <= state_d;
      code_q   <= code_d;
      result_q <= result_d;
      att_q    <= att_d;
      settle_q <= settle_d;
      wait_q   <= wait_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state and datapath updates; abort wins over everything else.
  always_comb begin
    state_d  = state;
    code_d   = code_q;
    result_d = result_q;
    att_d    = att_q;
    settle_d = settle_q;
    wait_d   = wait_q;
    tmo_d    = tmo_q;
    if (abort) begin
      state_d = S_IDLE;
      tmo_d   = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            state_d  = S_PRESENT;
            code_d   = '0;
            att_d    = '0;
            tmo_d    = 1'b0;
            settle_d = SETTLE_LOAD;
          end
        end
        S_PRESENT: begin
          if (settle_q == '0) begin
            if (lock_ready) begin
              state_d = S_TRY;
            end else begin
              state_d = S_WAIT_READY;
              wait_d  = '0;
            end
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end
        S_WAIT_READY: begin
          wait_d = wait_q + 1'b1;
          if (lock_ready) begin
            state_d = S_TRY;
          end else if (wait_q == WAIT_LAST) begin
            state_d = S_FAIL;
            tmo_d   = 1'b1;
          end
        end
        S_TRY: begin
          att_d = att_q + 1'b1;
          if (lock_match) begin
            state_d  = S_DONE;
            result_d = code_q;
          end else if (code_q == CODE_LAST) begin
            // Last candidate missed: stop here rather than wrap to 0.
            state_d = S_FAIL;
            tmo_d   = 1'b0;
          end else begin
            state_d  = S_PRESENT;
            code_d   = code_q + 1'b1;
            settle_d = SETTLE_LOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Status outputs are pure state decodes so reset drops them at once.
  assign try_out  = (state == S_TRY);
  assign busy     = (state == S_PRESENT) || (state == S_TRY) || (state == S_WAIT_READY);
  assign found    = (state == S_DONE);
  assign fail     = (state == S_FAIL);
  assign timeout  = tmo_q;
  assign code_out = code_q;
  assign result   = result_q;
  assign attempts = att_q;

endmodule

// File: tb/tb_code_lock_prober.sv
// Directed bench for code_lock_prober: two instances (SETTLE=1/WAIT_MAX=20
// and SETTLE=2/WAIT_MAX=255) each driven by a small responder model.
module tb_code_lock_prober;
  import code_lock_pkg::*;

  logic clk, rst_n;
  int   vecs, errs;

  // instance A: SETTLE=1, WAIT_MAX=20
  logic       start_a, abort_a, ready_a, match_a;
  logic [3:0] code_a, result_a;
  logic       try_a, busy_a, found_a, fail_a, tmo_a;
  logic [4:0] att_a;

  // instance B: SETTLE=2, default WAIT_MAX
  logic       start_b, abort_b, ready_b, match_b;
  logic [3:0] code_b, result_b;
  logic       try_b, busy_b, found_b, fail_b, tmo_b;
  logic [4:0] att_b;

  code_lock_prober #(.SETTLE(1), .WAIT_MAX(20)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .lock_ready(ready_a), .lock_match(match_a), .code_out(code_a),
    .try_out(try_a), .busy(busy_a), .found(found_a), .fail(fail_a),
    .timeout(tmo_a), .result(result_a), .attempts(att_a)
  );

  code_lock_prober #(.SETTLE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .lock_ready(ready_b), .lock_match(match_b), .code_out(code_b),
    .try_out(try_b), .busy(busy_b), .found(found_b), .fail(fail_b),
    .timeout(tmo_b), .result(result_b), .attempts(att_b)
  );

  always #5 clk = ~clk;

  // code_lock_model for A: combinational match, lockout of lock_len cycles
  // starting right after the lock_after-th miss.
  logic [3:0] secret_a;
  logic       secret_en_a;
  int         lock_after, lock_len, miss_cnt, lock_left;

  assign match_a = try_a && secret_en_a && (code_a == secret_a);
  assign ready_a = (lock_left == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt  <= 0;
      lock_left <= 0;
    end else begin
      if (lock_left > 0) lock_left <= lock_left - 1;
      if (try_a && !match_a) begin
        miss_cnt <= miss_cnt + 1;
        if (lock_after != 0 && miss_cnt + 1 == lock_after) lock_left <= lock_len;
      end
    end
  end

  // responder for B never matches and never locks out
  assign match_b = 1'b0;
  assign ready_b = 1'b1;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // start is sampled at edge 0; returns at the negedge of cycle 1
  task automatic kick_a();
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
  endtask

  // observes A from the current (cycle 1) negedge until found/fail or bound
  task automatic run_a(input int max_cyc, output int end_cyc, output int last_try,
                       output int last_code, output int tries, output bit consec);
    bit prev_try;
    prev_try = 1'b0; end_cyc = -1; last_try = -1; last_code = -1; tries = 0; consec = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (try_a) begin
        tries++;
        last_try  = c;
        last_code = int'(code_a);
        if (prev_try) consec = 1'b1;
      end
      prev_try = try_a;
      if (found_a || fail_a) begin
        end_cyc = c;
        break;
      end
      @(negedge clk);
    end
    if (end_cyc < 0) $display("FAIL run_a bound: no found/fail within %0d cycles", max_cyc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vecs++; if ({code_a, try_a, busy_a, found_a, fail_a, tmo_a, result_a, att_a} !== '0) begin
      errs++; $display("FAIL reset_a: got %h required 0", {code_a, try_a, busy_a, found_a, fail_a, tmo_a, result_a, att_a});
    end
    vecs++; if ({code_b, try_b, busy_b, found_b, fail_b, tmo_b, result_b, att_b} !== '0) begin
      errs++; $display("FAIL reset_b: got %h required 0", {code_b, try_b, busy_b, found_b, fail_b, tmo_b, result_b, att_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vecs++; if ({busy_a, try_a, code_a} !== '0) begin
      errs++; $display("FAIL idle_after_reset: busy/try/code %b/%b/%0d required 0/0/0", busy_a, try_a, code_a);
    end
  endtask

  task automatic test_plain_search();
    int e, lt, lc, n; bit cs;
    secret_a = 4'h5; secret_en_a = 1'b1; lock_after = 0; lock_len = 0;
    do_reset();
    kick_a();
    vecs++; if (busy_a !== 1'b1) begin errs++; $display("FAIL plain_busy: got %b required 1", busy_a); end
    run_a(200, e, lt, lc, n, cs);
    vecs++; if (lt !== 12 || lc !== 5) begin
      errs++; $display("FAIL plain_try: last try cycle %0d code %0d required 12 code 5", lt, lc);
    end
    vecs++; if (e !== 13 || found_a !== 1'b1) begin
      errs++; $display("FAIL plain_found: found at cycle %0d (found=%b) required 13", e, found_a);
    end
    vecs++; if (result_a !== 4'd5 || att_a !== 5'd6 || n !== 6) begin
      errs++; $display("FAIL plain_result: result %0d attempts %0d tries %0d required 5/6/6", result_a, att_a, n);
    end
    vecs++; if (cs !== 1'b0) begin errs++; $display("FAIL plain_consec_try: got %b required 0", cs); end
    repeat (3) @(negedge clk);
    vecs++; if (found_a !== 1'b1 || result_a !== 4'd5 || busy_a !== 1'b0) begin
      errs++; $display("FAIL plain_hold: found %b result %0d busy %b required 1/5/0", found_a, result_a, busy_a);
    end
  endtask

  // restart directly from DONE without reset
  task automatic test_back_to_back();
    int e, lt, lc, n; bit cs;
    secret_a = 4'h2;
    kick_a();
    vecs++; if (code_a !== 4'd0 || att_a !== 5'd0 || found_a !== 1'b0) begin
      errs++; $display("FAIL b2b_restart: code %0d att %0d found %b required 0/0/0", code_a, att_a, found_a);
    end
    run_a(200, e, lt, lc, n, cs);
    vecs++; if (lt !== 6 || e !== 7 || result_a !== 4'd2 || att_a !== 5'd3) begin
      errs++; $display("FAIL b2b_found: try %0d found %0d result %0d att %0d required 6/7/2/3", lt, e, result_a, att_a);
    end
  endtask

  task automatic test_lockout_recovery();
    int e, lt, lc, n; bit cs;
    secret_a = 4'h9; secret_en_a = 1'b1; lock_after = 3; lock_len = 10;
    do_reset();
    kick_a();
    run_a(200, e, lt, lc, n, cs);
    vecs++; if (lt !== 30 || lc !== 9) begin
      errs++; $display("FAIL lockout_try: last try %0d code %0d required 30 code 9", lt, lc);
    end
    vecs++; if (e !== 31 || found_a !== 1'b1 || result_a !== 4'd9 || att_a !== 5'd10) begin
      errs++; $display("FAIL lockout_found: cycle %0d found %b result %0d att %0d required 31/1/9/10", e, found_a, result_a, att_a);
    end
    vecs++; if (tmo_a !== 1'b0) begin errs++; $display("FAIL lockout_tmo: got %b required 0", tmo_a); end
  endtask

  task automatic test_lockout_timeout();
    int e, lt, lc, n; bit cs;
    secret_en_a = 1'b0; lock_after = 1; lock_len = 100000;
    do_reset();
    kick_a();
    run_a(200, e, lt, lc, n, cs);
    vecs++; if (e !== 24 || fail_a !== 1'b1 || tmo_a !== 1'b1) begin
      errs++; $display("FAIL timeout_fail: cycle %0d fail %b timeout %b required 24/1/1", e, fail_a, tmo_a);
    end
    vecs++; if (att_a !== 5'd1 || n !== 1 || found_a !== 1'b0) begin
      errs++; $display("FAIL timeout_attempts: att %0d tries %0d found %b required 1/1/0", att_a, n, found_a);
    end
    kick_a();
    vecs++; if (tmo_a !== 1'b0 || fail_a !== 1'b0 || busy_a !== 1'b1) begin
      errs++; $display("FAIL timeout_restart: timeout %b fail %b busy %b required 0/0/1", tmo_a, fail_a, busy_a);
    end
  endtask

  task automatic test_abort();
    int n;
    secret_en_a = 1'b0; lock_after = 0;
    do_reset();
    kick_a();
    for (int c = 1; c < 7; c++) @(negedge clk);
    abort_a = 1'b1; start_a = 1'b1;  // abort must win over start
    @(negedge clk);
    abort_a = 1'b0; start_a = 1'b0;
    vecs++; if (busy_a !== 1'b0 || found_a !== 1'b0 || fail_a !== 1'b0 || try_a !== 1'b0) begin
      errs++; $display("FAIL abort_idle: busy %b found %b fail %b try %b required 0/0/0/0", busy_a, found_a, fail_a, try_a);
    end
    vecs++; if (code_a !== 4'd3 || att_a !== 5'd3) begin
      errs++; $display("FAIL abort_keep: code %0d att %0d required 3/3", code_a, att_a);
    end
    n = 0;
    repeat (10) begin @(negedge clk); if (try_a || busy_a) n++; end
    vecs++; if (n !== 0) begin errs++; $display("FAIL abort_quiet: %0d active cycles required 0", n); end
    kick_a();
    vecs++; if (code_a !== 4'd0 || att_a !== 5'd0 || busy_a !== 1'b1) begin
      errs++; $display("FAIL abort_restart: code %0d att %0d busy %b required 0/0/1", code_a, att_a, busy_a);
    end
  endtask

  task automatic test_reset_mid_try();
    int n; bit seen;
    secret_en_a = 1'b0; lock_after = 0;
    do_reset();
    kick_a();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (try_a) seen = 1'b1; else @(negedge clk);
    end
    vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL rst_try_seen: got %b required 1", seen); end
    rst_n = 1'b0;
    #1;
    vecs++; if (try_a !== 1'b0) begin errs++; $display("FAIL rst_try_drop: got %b required 0", try_a); end
    vecs++; if ({code_a, busy_a, found_a, fail_a, tmo_a, result_a, att_a} !== '0) begin
      errs++; $display("FAIL rst_try_outputs: got %h required 0", {code_a, busy_a, found_a, fail_a, tmo_a, result_a, att_a});
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin @(negedge clk); if (try_a || busy_a || code_a != 4'd0) n++; end
    vecs++; if (n !== 0) begin errs++; $display("FAIL rst_try_stay_idle: %0d active cycles required 0", n); end
  endtask

  task automatic test_exhaustion();
    int e, lt, lc, n; bit wrap;
    logic [3:0] prev_code;
    do_reset();
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    e = -1; lt = -1; lc = -1; n = 0; wrap = 1'b0; prev_code = code_b;
    for (int c = 1; c <= 200; c++) begin
      if (prev_code == 4'd15 && code_b == 4'd0) wrap = 1'b1;
      prev_code = code_b;
      if (try_b) begin n++; lt = c; lc = int'(code_b); end
      if (found_b || fail_b) begin e = c; break; end
      @(negedge clk);
    end
    vecs++; if (lt !== 48 || lc !== 15) begin
      errs++; $display("FAIL exhaust_last_try: cycle %0d code %0d required 48 code 15", lt, lc);
    end
    vecs++; if (e !== 49 || fail_b !== 1'b1 || tmo_b !== 1'b0 || found_b !== 1'b0) begin
      errs++; $display("FAIL exhaust_fail: cycle %0d fail %b timeout %b found %b required 49/1/0/0", e, fail_b, tmo_b, found_b);
    end
    vecs++; if (att_b !== 5'd16 || n !== 16) begin
      errs++; $display("FAIL exhaust_attempts: att %0d tries %0d required 16/16", att_b, n);
    end
    repeat (5) begin
      @(negedge clk);
      if (code_b == 4'd0) wrap = 1'b1;
    end
    vecs++; if (wrap !== 1'b0 || code_b !== 4'd15 || fail_b !== 1'b1) begin
      errs++; $display("FAIL exhaust_hold: wrap %b code %0d fail %b required 0/15/1", wrap, code_b, fail_b);
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    secret_a = 4'h0; secret_en_a = 1'b0; lock_after = 0; lock_len = 0;
    vecs = 0; errs = 0;
    test_reset();
    test_plain_search();
    test_back_to_back();
    test_lockout_recovery();
    test_lockout_timeout();
    test_abort();
    test_reset_mid_try();
    test_exhaustion();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
